// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Execute-stage multiply/divide unit owning the HI/LO register pair.
//   mult/multu/div/divu start a 32-iteration sequential engine (shift-add
//   multiply, restoring divide) that runs on operand magnitudes and applies
//   sign correction on the final iteration before writing HI/LO.
//   mthi/mtlo write HI/LO directly when the engine is not running.
//
//   Optional build macro: MULDIV_FAST_MUL_EN
//     defined   - mult/multu use a single-cycle combinational 64-bit product
//     undefined - mult/multu use the 32-iteration shift-add engine
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   op_mult/op_multu/op_div/op_divu   start strobes
//   op_mthi/op_mtlo                   write rs_val into HI / LO
//   op_mfhi/op_mflo                   read requests (stall generation only)
//   rs_val     operand A (multiplicand / dividend / mthi-mtlo source)
//   rt_val     operand B (multiplier / divisor)
//   flush      abort in-flight operation
//   hi, lo     committed HI/LO contents
//   busy       engine running
//   done       one-cycle pulse after a mul/div writes HI/LO
//   div_zero   one-cycle pulse with done for a divide by zero
//   stall_req  busy and any op strobe present
//
// state  | meaning
// IDLE   | waiting for a start strobe; mthi/mtlo accepted
// RUN    | one engine iteration per edge; busy
// FIN    | done (and div_zero) pulse; new start or mthi/mtlo accepted

module hilo_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_mult,
   input  logic             op_multu,
   input  logic             op_div,
   input  logic             op_divu,
   input  logic             op_mthi,
   input  logic             op_mtlo,
   input  logic             op_mfhi,
   input  logic             op_mflo,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             stall_req
);

   localparam int CNT_W = $clog2(ITER);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   // mul: product accumulator; div: {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // mul: multiplicand shifted left each iteration
   logic [2*WIDTH-1:0] opa_q, opa_d;
   // mul: multiplier shifted right each iteration; div: divisor
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dz_flag_q, dz_flag_d;
   logic               done_q, done_d;
   logic               dz_pulse_q, dz_pulse_d;

   // start decode, priority mult > multu > div > divu
   logic               st_any, st_signed, st_div;
   logic [WIDTH-1:0]   a_mag, b_mag;

   assign st_any    = op_mult | op_multu | op_div | op_divu;
   assign st_signed = op_mult | (!op_multu & op_div);
   assign st_div    = !op_mult & !op_multu & (op_div | op_divu);
   // abs(0x80000000) wraps to 0x80000000, which the unsigned engine reads as 2^31
   assign a_mag     = (st_signed & rs_val[WIDTH-1]) ? -rs_val : rs_val;
   assign b_mag     = (st_signed & rt_val[WIDTH-1]) ? -rt_val : rt_val;

   // one engine iteration
   logic [2*WIDTH-1:0] div_sh, div_acc_n, acc_step;
   logic [WIDTH:0]     div_trial;
   logic               last_step;

   assign div_sh    = {acc_q[2*WIDTH-2:0], 1'b0};
   assign div_trial = {1'b0, div_sh[2*WIDTH-1:WIDTH]} - {1'b0, opb_q};
   assign div_acc_n = div_trial[WIDTH] ? div_sh
                                       : {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, opa_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, opb_q};
   assign acc_step  = is_div_q ? div_acc_n : fast_prod;
   assign last_step = !is_div_q || (cnt_q == CNT_W'(ITER - 1));
`else
   logic [2*WIDTH-1:0] mul_acc_n;
   assign mul_acc_n = opb_q[0] ? (acc_q + opa_q) : acc_q;
   assign acc_step  = is_div_q ? div_acc_n : mul_acc_n;
   assign last_step = (cnt_q == CNT_W'(ITER - 1));
`endif

   // sign correction of the final iteration result
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix, wb_hi, wb_lo;

   assign prod_fix = neg_res_q ? -acc_step : acc_step;
   assign quot_fix = neg_res_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
   assign rem_fix  = neg_rem_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
   assign wb_hi    = is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
   assign wb_lo    = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      acc_d      = acc_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      is_div_d   = is_div_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      dz_flag_d  = dz_flag_q;
      done_d     = 1'b0;
      dz_pulse_d = 1'b0;

      unique case (state_q)
         S_IDLE, S_FIN: begin
            state_d = S_IDLE;
            if (st_any) begin
               state_d   = S_RUN;
               cnt_d     = '0;
               is_div_d  = st_div;
               neg_res_d = st_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
               neg_rem_d = st_signed & rs_val[WIDTH-1];
               dz_flag_d = st_div & (rt_val == '0);
               opb_d     = b_mag;
               if (st_div) begin
                  acc_d = {{WIDTH{1'b0}}, a_mag};
                  opa_d = '0;
               end else begin
                  acc_d = '0;
                  opa_d = {{WIDTH{1'b0}}, a_mag};
               end
            end else if (op_mthi) begin
               hi_d = rs_val;
            end else if (op_mtlo) begin
               lo_d = rs_val;
            end
         end
         S_RUN: begin
            acc_d = acc_step;
            opa_d = opa_q << 1;
            if (!is_div_q) opb_d = opb_q >> 1;
            if (last_step) begin
               hi_d       = wb_hi;
               lo_d       = wb_lo;
               done_d     = 1'b1;
               dz_pulse_d = dz_flag_q;
               state_d    = S_FIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // flush discards the in-flight op and anything presented on the same edge
      if (flush) begin
         state_d    = S_IDLE;
         hi_d       = hi_q;
         lo_d       = lo_q;
         done_d     = 1'b0;
         dz_pulse_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         acc_q      <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dz_flag_q  <= 1'b0;
         done_q     <= 1'b0;
         dz_pulse_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         acc_q      <= acc_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         is_div_q   <= is_div_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         dz_flag_q  <= dz_flag_d;
         done_q     <= done_d;
         dz_pulse_q <= dz_pulse_d;
      end
   end

   assign hi        = hi_q;
   assign lo        = lo_q;
   assign busy      = (state_q == S_RUN);
   assign done      = done_q;
   assign div_zero  = dz_pulse_q;
   assign stall_req = busy & (op_mult | op_multu | op_div | op_divu |
                              op_mthi | op_mtlo | op_mfhi | op_mflo);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        op_mult, op_multu, op_div, op_divu;
   logic        op_mthi, op_mtlo, op_mfhi, op_mflo;
   logic [31:0] rs_val, rt_val;
   logic        flush;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero, stall_req;

   int n_total = 0;
   int n_bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_CYC = 1;
`else
   localparam int MUL_CYC = 32;
`endif
   localparam int DIV_CYC = 32;

   hilo_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_mult   (op_mult),
      .op_multu  (op_multu),
      .op_div    (op_div),
      .op_divu   (op_divu),
      .op_mthi   (op_mthi),
      .op_mtlo   (op_mtlo),
      .op_mfhi   (op_mfhi),
      .op_mflo   (op_mflo),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .flush     (flush),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .stall_req (stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // op: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
   // caller is at a negedge; strobe is held across one rising edge
   task automatic kick(input int op, input logic [31:0] a, input logic [31:0] b);
      rs_val   = a;
      rt_val   = b;
      op_mult  = (op == 0);
      op_multu = (op == 1);
      op_div   = (op == 2);
      op_divu  = (op == 3);
      op_mthi  = (op == 4);
      op_mtlo  = (op == 5);
      @(negedge clk);
      op_mult = 0; op_multu = 0; op_div = 0; op_divu = 0; op_mthi = 0; op_mtlo = 0;
   endtask

   task automatic wait_done(input string tag, input int exp_cyc, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo, input logic exp_dz);
      int cyc;
      cyc = 0;
      check({tag, ".busy_start"}, 64'(busy), 64'd1);
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, ".cycles"}, 64'(cyc), 64'(exp_cyc));
      check({tag, ".done"}, 64'(done), 64'd1);
      check({tag, ".busy_end"}, 64'(busy), 64'd0);
      check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
      check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
      check({tag, ".div_zero"}, 64'(div_zero), 64'(exp_dz));
   endtask

   task automatic run_op(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_dz);
      @(negedge clk);
      kick(op, a, b);
      wait_done(tag, exp_cyc, exp_hi, exp_lo, exp_dz);
      @(negedge clk);
      check({tag, ".done_drop"}, 64'(done), 64'd0);
      check({tag, ".dz_drop"}, 64'(div_zero), 64'd0);
   endtask

   initial begin
      int dones;
      rst = 1; flush = 0;
      op_mult = 0; op_multu = 0; op_div = 0; op_divu = 0;
      op_mthi = 0; op_mtlo = 0; op_mfhi = 0; op_mflo = 0;
      rs_val = 0; rt_val = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      check("rst.hi", 64'(hi), 64'd0);
      check("rst.lo", 64'(lo), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.done", 64'(done), 64'd0);
      check("rst.div_zero", 64'(div_zero), 64'd0);
      check("rst.stall", 64'(stall_req), 64'd0);

      run_op("multu_ff", 1, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_CYC, 32'hFFFFFFFE, 32'h00000001, 0);
      run_op("mult_neg", 0, 32'hFFFFFFFD, 32'd7, MUL_CYC, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
      run_op("mult_min", 0, 32'h80000000, 32'h80000000, MUL_CYC, 32'h40000000, 32'h00000000, 0);
      run_op("div_neg", 2, 32'hFFFFFFF9, 32'd2, DIV_CYC, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
      run_op("div_negdvs", 2, 32'd7, 32'hFFFFFFFE, DIV_CYC, 32'h00000001, 32'hFFFFFFFD, 0);
      run_op("divu_zero", 3, 32'd100, 32'd0, DIV_CYC, 32'd100, 32'hFFFFFFFF, 1);
      run_op("div_zero_neg", 2, 32'hFFFFFFFB, 32'd0, DIV_CYC, 32'hFFFFFFFB, 32'h00000001, 1);
      run_op("div_zero_pos", 2, 32'd9, 32'd0, DIV_CYC, 32'd9, 32'hFFFFFFFF, 1);
      run_op("div_ovf", 2, 32'h80000000, 32'hFFFFFFFF, DIV_CYC, 32'h00000000, 32'h80000000, 0);
      run_op("divu_big", 3, 32'hFFFFFFFF, 32'd3, DIV_CYC, 32'h00000000, 32'h55555555, 0);

      // back-to-back: new start presented during FIN
      @(negedge clk);
      kick(1, 32'd3, 32'd5);
      wait_done("b2b_mul", MUL_CYC, 32'd0, 32'd15, 0);
      kick(3, 32'd100, 32'd7);
      wait_done("b2b_div", DIV_CYC, 32'd2, 32'd14, 0);

      // mthi in IDLE
      @(negedge clk);
      kick(4, 32'h12345678, 32'd0);
      check("mthi.hi", 64'(hi), 64'h12345678);
      check("mthi.busy", 64'(busy), 64'd0);
      check("mthi.done", 64'(done), 64'd0);
      kick(5, 32'h0000BBBB, 32'd0);
      check("mtlo.lo", 64'(lo), 64'h0000BBBB);

      // stall during run, then flush
      kick(2, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      op_mflo = 1; op_mtlo = 1; rs_val = 32'd5;
      #1;
      check("stall.req", 64'(stall_req), 64'd1);
      @(negedge clk);
      op_mflo = 0; op_mtlo = 0;
      #1;
      check("stall.lo_kept", 64'(lo), 64'h0000BBBB);
      check("stall.busy", 64'(busy), 64'd1);
      check("stall.req_drop", 64'(stall_req), 64'd0);
      repeat (9) @(negedge clk);
      flush = 1;
      @(negedge clk);
      flush = 0;
      check("flush.busy", 64'(busy), 64'd0);
      check("flush.hi", 64'(hi), 64'h12345678);
      check("flush.lo", 64'(lo), 64'h0000BBBB);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("flush.no_done", 64'(dones), 64'd0);

      // reset during a running multiply
      kick(0, 32'd1234, 32'd5678);
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("rst_mid.hi", 64'(hi), 64'd0);
      check("rst_mid.lo", 64'(lo), 64'd0);
      check("rst_mid.busy", 64'(busy), 64'd0);
      check("rst_mid.done", 64'(done), 64'd0);
      repeat (40) @(negedge clk);
      check("rst_mid.lo_late", 64'(lo), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
